// File: rtl/chess_timer.sv
// Multi-player chess clock: one running countdown per player, per-second prescaler,
// Fischer increment on each move, low-time warning pulse and flag-fall detection.
module chess_timer #(
  parameter int CLK_HZ   = 100000000,
  parameter int PLAYERS  = 2,
  parameter int SEC_W    = 12,
  parameter int INIT_SEC = 600,
  parameter int INC_SEC  = 0,
  parameter int WARN_SEC = 10,
  localparam int AW      = (PLAYERS > 2) ? $clog2(PLAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     move_done,
  output logic [PLAYERS*SEC_W-1:0] time_flat,
  output logic [AW-1:0]            active,
  output logic [1:0]               state,
  output logic                     sec_tick,
  output logic                     warn,
  output logic                     timeout,
  output logic [AW-1:0]            loser
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam longint MAXV = (64'd1 << SEC_W) - 1;
  localparam logic [SEC_W-1:0] INIT_T = SEC_W'(INIT_SEC);
  localparam logic [SEC_W:0] INC_T  = (SEC_W+1)'((INC_SEC > MAXV) ? MAXV : INC_SEC);
  localparam logic [SEC_W:0] WARN_T = (SEC_W+1)'((WARN_SEC > MAXV) ? MAXV : WARN_SEC);
  localparam logic [AW-1:0] LAST_PLAYER = AW'(PLAYERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [SEC_W-1:0] times_reg  [PLAYERS];
  logic [SEC_W-1:0] times_next [PLAYERS];
  logic [AW-1:0]    active_reg, active_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic             timeout_reg, timeout_next;
  logic [AW-1:0]    loser_reg, loser_next;
  logic             sec_tick_reg, sec_tick_next;
  logic             warn_reg, warn_next;

  logic [SEC_W-1:0] cur_time;
  logic [SEC_W-1:0] dec_time;
  logic [AW-1:0]    next_player;
  logic             tick;

  // Increment with saturation at the all-ones value of the counter.
  function automatic logic [SEC_W-1:0] add_inc(input logic [SEC_W-1:0] t);
    logic [SEC_W:0] s;
    s = {1'b0, t} + INC_T;
    return s[SEC_W] ? {SEC_W{1'b1}} : s[SEC_W-1:0];
  endfunction

  assign cur_time    = times_reg[active_reg];
  assign dec_time    = cur_time - SEC_W'(1);
  assign next_player = (active_reg == LAST_PLAYER) ? '0 : active_reg + AW'(1);
  assign tick        = (presc_reg == PRESC_MAX);

  always_comb begin
    state_next    = state_reg;
    times_next    = times_reg;
    active_next   = active_reg;
    presc_next    = presc_reg;
    timeout_next  = timeout_reg;
    loser_next    = loser_reg;
    sec_tick_next = 1'b0;
    warn_next     = 1'b0;

    if (load) begin
      state_next   = ST_IDLE;
      times_next   = '{default: INIT_T};
      active_next  = '0;
      presc_next   = '0;
      timeout_next = 1'b0;
      loser_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) state_next = ST_RUN;
        end
        ST_RUN: begin
          // The whole RUN cycle is honoured even when pause arrives; pause only
          // selects the following state.
          if (pause) state_next = ST_PAUSED;
          if (tick) begin
            presc_next    = '0;
            sec_tick_next = 1'b1;
            if (cur_time <= SEC_W'(1)) begin
              // Flag falls: any coincident move is discarded and the clock freezes.
              times_next[active_reg] = '0;
              state_next             = ST_OVER;
              timeout_next           = 1'b1;
              loser_next             = active_reg;
            end else begin
              warn_next = ({1'b0, dec_time} <= WARN_T);
              if (move_done) begin
                times_next[active_reg] = add_inc(dec_time);
                active_next            = next_player;
              end else begin
                times_next[active_reg] = dec_time;
              end
            end
          end else begin
            presc_next = presc_reg + PW'(1);
            if (move_done) begin
              times_next[active_reg] = add_inc(cur_time);
              active_next            = next_player;
              presc_next             = '0;
            end
          end
        end
        ST_PAUSED: begin
          if (start) state_next = ST_RUN;
        end
        ST_OVER: begin
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      times_reg    <= '{default: INIT_T};
      active_reg   <= '0;
      presc_reg    <= '0;
      timeout_reg  <= 1'b0;
      loser_reg    <= '0;
      sec_tick_reg <= 1'b0;
      warn_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      times_reg    <= times_next;
      active_reg   <= active_next;
      presc_reg    <= presc_next;
      timeout_reg  <= timeout_next;
      loser_reg    <= loser_next;
      sec_tick_reg <= sec_tick_next;
      warn_reg     <= warn_next;
    end
  end

  generate
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_pack
      assign time_flat[gi*SEC_W +: SEC_W] = times_reg[gi];
    end
  endgenerate

  assign active   = active_reg;
  assign state    = state_reg;
  assign sec_tick = sec_tick_reg;
  assign warn     = warn_reg;
  assign timeout  = timeout_reg;
  assign loser    = loser_reg;

endmodule

// File: tb/tb_chess_timer.sv
// Directed bench for chess_timer with CLK_HZ=4, PLAYERS=3, SEC_W=4, INIT_SEC=3,
// INC_SEC=1, WARN_SEC=2; each check is an immediate assertion.
module tb_chess_timer;

  localparam int PLAYERS = 3;
  localparam int SEC_W   = 4;
  localparam int AW      = 2;

  logic                     clk = 1'b0;
  logic                     rst, load, start, pause, move_done;
  logic [PLAYERS*SEC_W-1:0] time_flat;
  logic [AW-1:0]            active;
  logic [1:0]               state;
  logic                     sec_tick, warn, timeout;
  logic [AW-1:0]            loser;

  int tests = 0;
  int fails = 0;

  chess_timer #(
    .CLK_HZ(4), .PLAYERS(PLAYERS), .SEC_W(SEC_W),
    .INIT_SEC(3), .INC_SEC(1), .WARN_SEC(2)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause),
    .move_done(move_done), .time_flat(time_flat), .active(active),
    .state(state), .sec_tick(sec_tick), .warn(warn), .timeout(timeout),
    .loser(loser)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [SEC_W-1:0] pt(input int p);
    return time_flat[p*SEC_W +: SEC_W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_tick;
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; move_done = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_times", time_flat, 12'h333);
    chk("rst_active", active, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tick", sec_tick, 0);
    step();
    chk("post_rst_idle", state, 0);

    $display("[TB] scenario: first second");
    start = 1'b1; step(); start = 1'b0;
    chk("a_run", state, 1);
    cyc(3);
    chk("a_no_early_tick", sec_tick, 0);
    step();
    chk("a_tick", sec_tick, 1);
    chk("a_warn", warn, 1);
    chk("a_p0", pt(0), 2);
    chk("a_active", active, 0);
    step();
    chk("a_tick_pulse", sec_tick, 0);

    $display("[TB] scenario: moves and handover");
    load = 1'b1; step(); load = 1'b0;
    chk("b_load_state", state, 0);
    chk("b_load_times", time_flat, 12'h333);
    start = 1'b1; step(); start = 1'b0;
    cyc(2);
    move_done = 1'b1; step(); move_done = 1'b0;
    chk("b_p0_inc", pt(0), 4);
    chk("b_active1", active, 1);
    cyc(3);
    chk("b_presc_cleared", sec_tick, 0);
    step();
    chk("b_tick_p1", sec_tick, 1);
    chk("b_p1_dec", pt(1), 2);
    move_done = 1'b1;
    step();
    chk("b_active2", active, 2);
    chk("b_p1_inc", pt(1), 3);
    step();
    chk("b_active_wrap", active, 0);
    chk("b_p2_inc", pt(2), 4);
    step();
    chk("b_active1_again", active, 1);
    chk("b_p0_inc2", pt(0), 5);
    move_done = 1'b0;

    $display("[TB] scenario: pause and resume");
    load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    cyc(2);
    pause = 1'b1; step(); pause = 1'b0;
    chk("c_paused", state, 2);
    seen_tick = 1'b0;
    pause = 1'b1; move_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sec_tick) seen_tick = 1'b1;
    end
    pause = 1'b0; move_done = 1'b0;
    chk("c_no_tick_paused", seen_tick, 0);
    chk("c_p0_frozen", pt(0), 3);
    chk("c_active_frozen", active, 0);
    chk("c_still_paused", state, 2);
    start = 1'b1; step(); start = 1'b0;
    chk("c_resumed", state, 1);
    chk("c_no_tick_yet", sec_tick, 0);
    step();
    chk("c_tick_after_resume", sec_tick, 1);
    chk("c_p0_dec", pt(0), 2);
    start = 1'b1; pause = 1'b1; step(); start = 1'b0; pause = 1'b0;
    chk("c_pause_dominates", state, 2);

    $display("[TB] scenario: flag fall");
    load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    cyc(11);
    chk("d_p0_one", pt(0), 1);
    chk("d_running", state, 1);
    step();
    chk("d_over", state, 3);
    chk("d_timeout", timeout, 1);
    chk("d_loser", loser, 0);
    chk("d_p0_zero", pt(0), 0);
    chk("d_tick", sec_tick, 1);
    chk("d_no_warn", warn, 0);
    move_done = 1'b1; start = 1'b1;
    cyc(2);
    move_done = 1'b0; start = 1'b0;
    chk("d_over_held", state, 3);
    chk("d_active_frozen", active, 0);
    chk("d_p0_stays", pt(0), 0);
    chk("d_p1_untouched", pt(1), 3);
    chk("d_timeout_held", timeout, 1);
    load = 1'b1; start = 1'b1; step(); load = 1'b0; start = 1'b0;
    chk("d_load_idle", state, 0);
    chk("d_load_timeout", timeout, 0);
    chk("d_load_times", time_flat, 12'h333);

    $display("[TB] scenario: move on flag tick");
    start = 1'b1; step(); start = 1'b0;
    cyc(11);
    chk("e_p0_one", pt(0), 1);
    move_done = 1'b1; step(); move_done = 1'b0;
    chk("e_over", state, 3);
    chk("e_loser", loser, 0);
    chk("e_active_kept", active, 0);
    chk("e_p0_zero", pt(0), 0);
    chk("e_p1_untouched", pt(1), 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("e_rst_idle", state, 0);
    chk("e_rst_timeout", timeout, 0);
    chk("e_rst_times", time_flat, 12'h333);

    $display("[TB] scenario: increment saturation");
    start = 1'b1; step(); start = 1'b0;
    move_done = 1'b1;
    cyc(36);
    chk("e_all_max", time_flat, 12'hFFF);
    chk("e_active_after36", active, 0);
    cyc(3);
    move_done = 1'b0;
    chk("e_p0_sat", pt(0), 15);
    chk("e_all_sat", time_flat, 12'hFFF);
    chk("e_active_after39", active, 0);

    $display("[TB] scenario: load and rst while running");
    load = 1'b1; step(); load = 1'b0;
    chk("f_load_idle", state, 0);
    chk("f_load_times", time_flat, 12'h333);
    chk("f_load_active", active, 0);
    start = 1'b1; step(); start = 1'b0;
    cyc(3);
    rst = 1'b1; move_done = 1'b1; step(); rst = 1'b0; move_done = 1'b0;
    chk("f_rst_no_tick", sec_tick, 0);
    chk("f_rst_no_warn", warn, 0);
    chk("f_rst_idle", state, 0);
    chk("f_rst_times", time_flat, 12'h333);
    chk("f_rst_active", active, 0);
    step();
    chk("f_idle_after_rst", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
